// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM encoding,
// oversampling/frame geometry and the clock handler's baud code meanings.
package uart_tx_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   localparam int OVERSAMPLE = 16;
   localparam int FRAME_BITS = 10;

   // Baud codes understood by the clock handler.
   localparam logic [2:0] BAUD_9600     = 3'd0;
   localparam logic [2:0] BAUD_19200    = 3'd1;
   localparam logic [2:0] BAUD_38400    = 3'd2;
   localparam logic [2:0] BAUD_57600    = 3'd3;
   localparam logic [2:0] BAUD_115200   = 3'd4;
   localparam logic [2:0] BAUD_CODE_MAX = BAUD_115200;

   function automatic logic baud_code_ok(input logic [2:0] code);
      return code <= BAUD_CODE_MAX;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: the pointer holds the last granted index and the search
// starts just after it; the pointer moves only when advance accepts a grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last;
   logic [PW-1:0] win;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      grant = '0;
      win   = last;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = PW'((int'(last) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            win        = idx;
            found      = 1'b1;
         end
      end
   end

   // Reset to N-1 so that requester 0 is the first winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= PW'(N - 1);
      end else if (advance && found) begin
         last <= win;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmit line between NREQ requesters (round-robin) and
// owns the baud code driven to the clock handler, changing it only between frames.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick16,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   data,
   output logic [NREQ-1:0]          gnt,
   input  logic                     baud_req_valid,
   input  logic [2:0]               baud_req,
   output logic [2:0]               baud_sel,
   output logic                     baud_ack,
   output logic                     baud_err,
   output logic                     tx,
   output logic                     busy,
   output logic [2:0]               state_dbg
);

   // Handshake: req is a level held together with its data until the one-clk
   // gnt pulse; the byte is captured on the edge that raises gnt, and a req
   // still high after gnt is a request for the requester's next byte.

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);

   state_t              state, next_state;
   logic [3:0]          tcnt;
   logic [2:0]          bcnt;
   logic [DATA_W-1:0]   shift;
   logic [DATA_W-1:0]   sel_data;
   logic [NREQ-1:0]     arb_grant;
   logic                arb_advance;
   logic                apply_baud;
   logic                bit_end;
   logic                pending;
   logic [2:0]          pending_code;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   assign bit_end   = tick16 && (tcnt == TICK_LAST) && (state != ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      arb_advance = 1'b0;
      apply_baud  = 1'b0;
      tx          = 1'b1;
      case (state)
         ST_IDLE: begin
            // A pending baud change always wins over waiting requesters.
            if (pending) begin
               apply_baud = 1'b1;
               next_state = ST_SETTLE;
            end else if (|req) begin
               arb_advance = 1'b1;
               next_state  = ST_START;
            end
         end
         ST_START: begin
            tx = 1'b0;
            if (bit_end) next_state = ST_DATA;
         end
         ST_DATA: begin
            tx = shift[0];
            if (bit_end && bcnt == LAST_BIT) next_state = ST_STOP;
         end
         ST_STOP:   if (bit_end) next_state = ST_IDLE;
         ST_SETTLE: if (bit_end) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) sel_data = sel_data | data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt          <= '0;
         baud_sel     <= BAUD_9600;
         baud_ack     <= 1'b0;
         baud_err     <= 1'b0;
         pending      <= 1'b0;
         pending_code <= BAUD_9600;
         tcnt         <= '0;
         bcnt         <= '0;
         shift        <= '0;
      end else begin
         gnt      <= arb_advance ? arb_grant : '0;
         baud_ack <= apply_baud;
         baud_err <= baud_req_valid && !baud_code_ok(baud_req);
         if (apply_baud) baud_sel <= pending_code;
         // A fresh valid code arriving while the old one is applied stays pending.
         if (baud_req_valid && baud_code_ok(baud_req)) begin
            pending      <= 1'b1;
            pending_code <= baud_req;
         end else if (apply_baud) begin
            pending <= 1'b0;
         end
         if (state == ST_IDLE)  tcnt <= '0;
         else if (tick16)       tcnt <= tcnt + 4'd1;
         if (state == ST_START)                 bcnt <= '0;
         else if (state == ST_DATA && bit_end)  bcnt <= bcnt + 3'd1;
         if (arb_advance)                       shift <= sel_data;
         else if (state == ST_DATA && bit_end)  shift <= {1'b0, shift[DATA_W-1:1]};
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: grant and frame monitors pop
// expectations queued by the scenario tasks.
module tb_uart_tx_scheduler;
   import uart_tx_scheduler_pkg::*;

   localparam int NREQ     = 4;
   localparam int DATA_W   = 8;
   localparam int TICK_DIV = 3;
   localparam int FRAME_TICKS = FRAME_BITS * OVERSAMPLE;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   tick16;
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] data;
   logic [NREQ-1:0]        gnt;
   logic                   baud_req_valid;
   logic [2:0]             baud_req;
   logic [2:0]             baud_sel;
   logic                   baud_ack;
   logic                   baud_err;
   logic                   tx;
   logic                   busy;
   logic [2:0]             state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   int                gnt_q[$];

   uart_tx_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .tick16         (tick16),
      .req            (req),
      .data           (data),
      .gnt            (gnt),
      .baud_req_valid (baud_req_valid),
      .baud_req       (baud_req),
      .baud_sel       (baud_sel),
      .baud_ack       (baud_ack),
      .baud_err       (baud_err),
      .tx             (tx),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock, reset, tick source ----------------
   always #5 clk = ~clk;

   initial begin
      int div_cnt;
      div_cnt = 0;
      tick16  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         div_cnt = (div_cnt + 1) % TICK_DIV;
         tick16  = (div_cnt == 0);
      end
   end

   // ---------------- grant monitor ----------------
   always @(negedge clk) begin
      int e;
      logic [NREQ-1:0] exp_oh;
      if (!rst && gnt !== '0) begin
         n_checks++;
         if (gnt_q.size() == 0) begin
            n_fail++;
            $display("FAIL gnt_order: got %b, expected no grant", gnt);
         end else begin
            e = gnt_q.pop_front();
            exp_oh = '0;
            exp_oh[e] = 1'b1;
            if (gnt !== exp_oh) begin
               n_fail++;
               $display("FAIL gnt_order: got %b, expected %b", gnt, exp_oh);
            end
         end
         n_checks++;
         if (tx !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gnt_tx_busy: got tx=%b busy=%b, expected tx=0 busy=1", tx, busy);
         end
      end
   end

   // ---------------- serial frame monitor ----------------
   bit         in_frame = 1'b0;
   bit         post_chk = 1'b0;
   bit         shape_bad;
   int         nt, cur_b;
   logic [9:0] bits;

   always @(negedge clk) begin
      int b;
      logic [DATA_W-1:0] e;
      if (rst) begin
         in_frame = 1'b0;
         post_chk = 1'b0;
      end else begin
         if (post_chk) begin
            post_chk = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || tx !== 1'b1) begin
               n_fail++;
               $display("FAIL post_frame_idle: got busy=%b tx=%b, expected busy=0 tx=1", busy, tx);
            end
         end
         if (!in_frame && tx === 1'b0) begin
            in_frame  = 1'b1;
            nt        = 0;
            cur_b     = -1;
            shape_bad = 1'b0;
         end
         if (in_frame) begin
            b = nt / OVERSAMPLE;
            if (b != cur_b) begin
               bits[b] = tx;
               cur_b   = b;
            end else if (tx !== bits[b]) begin
               shape_bad = 1'b1;
            end
            if (busy !== 1'b1) shape_bad = 1'b1;
            if (tick16) nt++;
            if (nt == FRAME_TICKS) begin
               in_frame = 1'b0;
               post_chk = 1'b1;
               n_checks++;
               if (shape_bad || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL frame_shape: got bits=%b glitch=%0d, expected start 0, stop 1, 16 ticks per bit",
                           bits, shape_bad);
               end
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL frame_data: got %h, expected no frame", bits[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  if (bits[8:1] !== e) begin
                     n_fail++;
                     $display("FAIL frame_data: got %h, expected %h", bits[8:1], e);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_data(input int i, input logic [DATA_W-1:0] v);
      data[i*DATA_W +: DATA_W] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      baud_req_valid = 1'b0;
      baud_req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_baud(input logic [2:0] code);
      @(posedge clk); #1;
      baud_req_valid = 1'b1;
      baud_req = code;
      @(posedge clk); #1;
      baud_req_valid = 1'b0;
   endtask

   task automatic wait_gnt(output int idle);
      idle = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (gnt !== '0) return;
         if (busy === 1'b0) idle++;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_gnt: got no grant within 2000 cycles, expected a grant");
   endtask

   task automatic wait_idle(output int ticks);
      ticks = 0;
      for (int i = 0; i < 2000; i++) begin
         if (busy === 1'b0) return;
         if (tick16) ticks++;
         @(negedge clk);
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy high for 2000 cycles, expected idle");
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || gnt !== '0 || busy !== 1'b0 || baud_sel !== BAUD_9600 ||
          baud_ack !== 1'b0 || baud_err !== 1'b0 || state_dbg !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_values: got tx=%b gnt=%b busy=%b sel=%0d ack=%b err=%b st=%0d, expected 1 0 0 0 0 0 0",
                  tx, gnt, busy, baud_sel, baud_ack, baud_err, state_dbg);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
         n_fail++;
         $display("FAIL idle_hold: got tx=%b busy=%b st=%0d, expected 1 0 0", tx, busy, state_dbg);
      end
   endtask

   task automatic test_single_byte();
      int idle, ticks;
      do_reset();
      set_data(0, 8'hA5);
      gnt_q.push_back(0);
      exp_q.push_back(8'hA5);
      @(posedge clk); #1;
      req = 4'b0001;
      wait_gnt(idle);
      req = '0;
      n_checks++;
      if (idle !== 1) begin
         n_fail++;
         $display("FAIL gnt_latency: got %0d idle cycles, expected 1", idle);
      end
      wait_idle(ticks);
      n_checks++;
      if (ticks !== FRAME_TICKS) begin
         n_fail++;
         $display("FAIL frame_ticks: got %0d, expected %0d", ticks, FRAME_TICKS);
      end
   endtask

   task automatic test_round_robin();
      int idle, ticks;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_data(i, DATA_W'(8'h11 * (i + 1)));
      for (int k = 0; k < 5; k++) begin
         gnt_q.push_back(k % NREQ);
         exp_q.push_back(DATA_W'(8'h11 * ((k % NREQ) + 1)));
      end
      @(posedge clk); #1;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(idle);
         if (k > 0) begin
            n_checks++;
            if (idle !== 1) begin
               n_fail++;
               $display("FAIL rr_gap: got %0d idle cycles before grant %0d, expected 1", idle, k);
            end
         end
      end
      req = '0;
      wait_idle(ticks);
   endtask

   task automatic test_baud_mid_frame();
      int idle, ticks, n;
      bit early;
      do_reset();
      set_data(0, 8'h3C);
      set_data(1, 8'h96);
      gnt_q.push_back(0); exp_q.push_back(8'h3C);
      gnt_q.push_back(1); exp_q.push_back(8'h96);
      @(posedge clk); #1;
      req = 4'b0001;
      wait_gnt(idle);
      req = 4'b0010;
      repeat (40) @(negedge clk);
      pulse_baud(BAUD_57600);
      wait_idle(ticks);
      n_checks++;
      if (baud_sel !== BAUD_9600 || baud_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL baud_hold: got sel=%0d ack=%b, expected sel=0 ack=0", baud_sel, baud_ack);
      end
      @(negedge clk);
      n_checks++;
      if (baud_ack !== 1'b1 || baud_sel !== BAUD_57600 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL baud_apply: got ack=%b sel=%0d busy=%b, expected 1 3 1", baud_ack, baud_sel, busy);
      end
      n = 0;
      early = 1'b0;
      for (int i = 0; i < 500 && busy === 1'b1; i++) begin
         if (gnt !== '0) early = 1'b1;
         if (tick16) n++;
         @(negedge clk);
      end
      n_checks++;
      if (n !== OVERSAMPLE || early) begin
         n_fail++;
         $display("FAIL settle_ticks: got %0d ticks early_gnt=%0d, expected %0d ticks no grant", n, early, OVERSAMPLE);
      end
      wait_gnt(idle);
      req = '0;
      wait_idle(ticks);
   endtask

   task automatic test_baud_err_last_wins();
      int idle, ticks, n_ack;
      logic [2:0] sel_at_ack;
      do_reset();
      @(posedge clk); #1;
      baud_req_valid = 1'b1;
      baud_req = 3'd6;
      @(negedge clk);
      n_checks++;
      if (baud_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_early: got %b, expected 0", baud_err);
      end
      @(posedge clk); #1;
      baud_req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (baud_err !== 1'b1 || baud_sel !== BAUD_9600) begin
         n_fail++;
         $display("FAIL err_pulse: got err=%b sel=%0d, expected err=1 sel=0", baud_err, baud_sel);
      end
      @(negedge clk);
      n_checks++;
      if (baud_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_no_pending: got err=%b busy=%b, expected 0 0", baud_err, busy);
      end
      set_data(2, 8'h5A);
      gnt_q.push_back(2); exp_q.push_back(8'h5A);
      @(posedge clk); #1;
      req = 4'b0100;
      wait_gnt(idle);
      req = '0;
      repeat (20) @(negedge clk);
      pulse_baud(BAUD_19200);
      repeat (20) @(negedge clk);
      pulse_baud(BAUD_38400);
      n_ack = 0;
      sel_at_ack = '0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (baud_ack === 1'b1) begin
            n_ack++;
            sel_at_ack = baud_sel;
         end
         if (n_ack > 0 && busy === 1'b0) break;
      end
      repeat (40) begin
         @(negedge clk);
         if (baud_ack === 1'b1) n_ack++;
      end
      n_checks++;
      if (n_ack !== 1 || sel_at_ack !== BAUD_38400) begin
         n_fail++;
         $display("FAIL last_wins: got %0d acks sel=%0d, expected 1 ack sel=2", n_ack, sel_at_ack);
      end
   endtask

   task automatic test_simultaneous();
      int ticks;
      do_reset();
      set_data(0, 8'hC3);
      gnt_q.push_back(0); exp_q.push_back(8'hC3);
      @(posedge clk); #1;
      req = 4'b0001;
      baud_req_valid = 1'b1;
      baud_req = BAUD_115200;
      @(posedge clk); #1;
      baud_req_valid = 1'b0;
      req = '0;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL simul_gnt: got %b, expected 0001", gnt);
      end
      wait_idle(ticks);
      @(negedge clk);
      n_checks++;
      if (baud_ack !== 1'b1 || baud_sel !== BAUD_115200) begin
         n_fail++;
         $display("FAIL simul_baud: got ack=%b sel=%0d, expected 1 4", baud_ack, baud_sel);
      end
      wait_idle(ticks);
   endtask

   task automatic test_reset_mid_frame();
      int idle, ticks, n;
      do_reset();
      set_data(0, 8'hA5);
      set_data(1, 8'h77);
      gnt_q.push_back(0); exp_q.push_back(8'hA5);
      @(posedge clk); #1;
      req = 4'b0001;
      wait_gnt(idle);
      req = '0;
      n = 0;
      for (int i = 0; i < 1000 && n < 88; i++) begin
         if (tick16) n++;
         @(negedge clk);
      end
      n_checks++;
      if (tx !== 1'b0 || state_dbg !== ST_DATA) begin
         n_fail++;
         $display("FAIL pre_reset_bit4: got tx=%b st=%0d, expected tx=0 st=%0d", tx, state_dbg, ST_DATA);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || gnt !== '0 || baud_sel !== BAUD_9600 || state_dbg !== ST_IDLE) begin
         n_fail++;
         $display("FAIL async_reset: got tx=%b busy=%b gnt=%b sel=%0d st=%0d, expected 1 0 0 0 0",
                  tx, busy, gnt, baud_sel, state_dbg);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gnt_q.push_back(0); exp_q.push_back(8'hA5);
      @(posedge clk); #1;
      req = 4'b0011;
      wait_gnt(idle);
      req = '0;
      wait_idle(ticks);
   endtask

   task automatic test_withdraw();
      int idle, ticks;
      do_reset();
      set_data(1, 8'hE1);
      set_data(2, 8'h2D);
      gnt_q.push_back(1); exp_q.push_back(8'hE1);
      gnt_q.push_back(1); exp_q.push_back(8'hE1);
      @(posedge clk); #1;
      req = 4'b0010;
      wait_gnt(idle);
      repeat (30) @(negedge clk);
      req = 4'b0110;
      repeat (100) @(negedge clk);
      req = 4'b0010;
      wait_gnt(idle);
      req = '0;
      wait_idle(ticks);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      req = '0;
      data = '0;
      baud_req_valid = 1'b0;
      baud_req = '0;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_baud_mid_frame();
      test_baud_err_last_wins();
      test_simultaneous();
      test_reset_mid_frame();
      test_withdraw();
      repeat (5) @(negedge clk);
      n_checks++;
      if (gnt_q.size() !== 0) begin
         n_fail++;
         $display("FAIL gnt_q_drained: got %0d pending grants, expected 0", gnt_q.size());
      end
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL exp_q_drained: got %0d pending frames, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
